sfx_scheduler: RTL and testbench

// - Shares the single speaker tone datapath between four game sound requesters
//   (game over, line clear, piece drop, rotate).
// - Latches request pulses, arbitrates by fixed priority, then plays the

---
 rtl/sfx_pkg.sv | 45 ++++
 rtl/sfx_tick_gen.sv | 29 ++
 rtl/sfx_scheduler.sv | 152 +++++++++++++++
 tb/tb_sfx_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared types and the effect note ROM for the sound-effect scheduler.
package sfx_pkg;

    typedef enum logic [1:0] {
        SFX_GAME_OVER,
        SFX_LINE_CLEAR,
        SFX_DROP,
        SFX_ROTATE
    } sfx_id_t;

    typedef struct packed {
        logic [11:0] freq;
        logic [9:0]  dur;
    } sfx_note_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        NEXT
    } sfx_state_t;

    // A zero duration terminates an effect's note list early.
    function automatic sfx_note_t sfx_rom(input sfx_id_t id, input logic [1:0] idx);
        sfx_note_t  note;
        logic [3:0] key;
        key  = {id, idx};
        note = '{freq: 12'd0, dur: 10'd0};
        case (key)
            4'b00_00: note = '{freq: 12'd659,  dur: 10'd400};
            4'b00_01: note = '{freq: 12'd523,  dur: 10'd400};
            4'b00_10: note = '{freq: 12'd587,  dur: 10'd400};
            4'b00_11: note = '{freq: 12'd494,  dur: 10'd600};
            4'b01_00: note = '{freq: 12'd523,  dur: 10'd60};
            4'b01_01: note = '{freq: 12'd659,  dur: 10'd60};
            4'b01_10: note = '{freq: 12'd784,  dur: 10'd60};
            4'b01_11: note = '{freq: 12'd1047, dur: 10'd120};
            4'b10_00: note = '{freq: 12'd196,  dur: 10'd40};
            4'b11_00: note = '{freq: 12'd880,  dur: 10'd20};
            default:  note = '{freq: 12'd0,    dur: 10'd0};
        endcase
        return note;
    endfunction

endpackage

// File: rtl/sfx_tick_gen.sv
// Free-running divider: one-cycle tick every FCLK/TICK_HZ clocks.
module sfx_tick_gen #(
    parameter int unsigned FCLK    = 50_000_000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned DIV   = FCLK / TICK_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_q == TERM) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = (cnt_q == TERM);

endmodule

// File: rtl/sfx_scheduler.sv
// Latches sound requests, arbitrates by fixed priority and sequences ROM notes.
// Optional feature: define SFX_PREEMPT_EN to let higher-priority requests abort playback.
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int unsigned FCLK    = 50_000_000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               mute,
    output logic [11:0]        freq_hz,
    output logic               tone_en,
    output logic               busy,
    output logic [1:0]         active_id,
    output logic               done
);

    sfx_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [1:0]         load_id_q, load_id_d;
    logic [1:0]         active_id_q, active_id_d;
    logic [1:0]         note_idx_q, note_idx_d;
    logic [11:0]        freq_q, freq_d;
    logic [9:0]         ms_cnt_q, ms_cnt_d;
    logic               done_q, done_d;
    logic               tick;
    logic [1:0]         pick_id;
    logic [1:0]         next_idx;
    sfx_note_t          first_note, next_note;
`ifdef SFX_PREEMPT_EN
    logic               preempt;
`endif

    sfx_tick_gen #(
        .FCLK    (FCLK),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Lowest set index wins.
    always_comb begin
        pick_id = 2'd0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (pending_q[i]) pick_id = 2'(i);
        end
    end

`ifdef SFX_PREEMPT_EN
    always_comb begin
        preempt = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pending_q[i] && (2'(i) < active_id_q)) preempt = 1'b1;
        end
    end
`endif

    assign next_idx   = note_idx_q + 2'd1;
    assign first_note = sfx_rom(sfx_id_t'(load_id_q), 2'd0);
    assign next_note  = sfx_rom(sfx_id_t'(active_id_q), next_idx);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | req;
        load_id_d   = load_id_q;
        active_id_d = active_id_q;
        note_idx_d  = note_idx_q;
        freq_d      = freq_q;
        ms_cnt_d    = ms_cnt_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    load_id_d = pick_id;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                // A request arriving this cycle for the same id keeps it pending.
                pending_d[load_id_q] = req[load_id_q];
                active_id_d          = load_id_q;
                note_idx_d           = 2'd0;
                freq_d               = first_note.freq;
                ms_cnt_d             = first_note.dur;
                state_d              = PLAY;
            end
            PLAY: begin
                if (tick) begin
                    if (ms_cnt_q != 10'd0) ms_cnt_d = ms_cnt_q - 10'd1;
                    if (ms_cnt_q <= 10'd1) state_d = NEXT;
                end
            end
            NEXT: begin
                if (note_idx_q == 2'd3 || next_note.dur == 10'd0) begin
                    done_d  = 1'b1;
                    freq_d  = 12'd0;
                    state_d = IDLE;
                end else begin
                    note_idx_d = next_idx;
                    freq_d     = next_note.freq;
                    ms_cnt_d   = next_note.dur;
                    state_d    = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SFX_PREEMPT_EN
        if ((state_q == PLAY || state_q == NEXT) && preempt) begin
            done_d    = 1'b1;
            freq_d    = freq_q;
            load_id_d = pick_id;
            state_d   = LOAD;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            load_id_q   <= 2'd0;
            active_id_q <= 2'd0;
            note_idx_q  <= 2'd0;
            freq_q      <= 12'd0;
            ms_cnt_q    <= 10'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            load_id_q   <= load_id_d;
            active_id_q <= active_id_d;
            note_idx_q  <= note_idx_d;
            freq_q      <= freq_d;
            ms_cnt_q    <= ms_cnt_d;
            done_q      <= done_d;
        end
    end

    assign freq_hz   = freq_q;
    assign tone_en   = (freq_q != 12'd0) && !mute;
    assign busy      = (state_q != IDLE);
    assign active_id = active_id_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Self-checking bench for sfx_scheduler: directed vectors, random trials, async reset.
`timescale 1ns/1ps
module tb_sfx_scheduler;

    localparam int unsigned FCLK    = 10_000;
    localparam int unsigned TICK_HZ = 1000;
    localparam int          CPT     = 10;  // clocks per tick
`ifdef SFX_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = 4'd0;
    logic        mute = 1'b0;
    logic [11:0] freq_hz;
    logic        tone_en;
    logic        busy;
    logic [1:0]  active_id;
    logic        done;

    sfx_scheduler #(
        .FCLK    (FCLK),
        .TICK_HZ (TICK_HZ),
        .NUM_REQ (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .mute      (mute),
        .freq_hz   (freq_hz),
        .tone_en   (tone_en),
        .busy      (busy),
        .active_id (active_id),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct { int freq; int len; } seg_t;
    typedef struct { int freq; int dur; bit skip; } exp_seg_t;
    typedef struct {
        logic [3:0] first;
        logic [3:0] mid;
        int         delay;
        logic       mute_v;
        int         exp_n;
        int         exp_first_freq;
    } vec_t;

    int rom_f [4][4] = '{'{659, 523, 587, 494}, '{523, 659, 784, 1047},
                         '{196, 0, 0, 0}, '{880, 0, 0, 0}};
    int rom_d [4][4] = '{'{400, 400, 400, 600}, '{60, 60, 60, 120},
                         '{40, 0, 0, 0}, '{20, 0, 0, 0}};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    seg_t obs_q[$];
    int   done_id_q[$];
    int   done_cyc_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 4;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Tracks constant-frequency runs and done pulses; checks tone_en every cycle.
    initial begin
        int   seg_freq;
        int   seg_len;
        seg_t s;
        seg_freq = 0;
        seg_len  = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("tone_en", int'(tone_en), int'(freq_hz != 12'd0 && !mute));
                if (int'(freq_hz) != seg_freq) begin
                    if (seg_freq != 0) begin
                        s.freq = seg_freq;
                        s.len  = seg_len;
                        obs_q.push_back(s);
                    end
                    seg_freq = int'(freq_hz);
                    seg_len  = 1;
                end else begin
                    seg_len++;
                end
                if (done === 1'b1) begin
                    done_id_q.push_back(int'(active_id));
                    done_cyc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic push_effect(inout exp_seg_t q[$], input int id, input bit truncated);
        exp_seg_t e;
        for (int n = 0; n < 4; n++) begin
            if (rom_d[id][n] == 0) break;
            e.freq = rom_f[id][n];
            e.dur  = rom_d[id][n];
            e.skip = truncated;
            q.push_back(e);
            if (truncated) break;
        end
    endtask

    // Starts from idle at posedge+1; ends at posedge+1 once the scheduler is quiet.
    task automatic run_trial(input vec_t v, input string tag);
        exp_seg_t   exp_q[$];
        int         exp_done[$];
        int         fid;
        logic [3:0] rest;
        bit         pre;
        int         mid_cyc;
        int         quiet;
        int         guard;

        // Reference: first effect, then every still-pending id in priority order.
        fid  = lowest(v.first);
        rest = (v.first & ~(4'b0001 << fid)) | v.mid;
        pre  = PREEMPT && (v.mid != 4'd0) && (lowest(v.mid) < fid);
        push_effect(exp_q, fid, pre);
        exp_done.push_back(fid);
        for (int i = 0; i < 4; i++) begin
            if (rest[i]) begin
                push_effect(exp_q, i, 1'b0);
                exp_done.push_back(i);
            end
        end

        obs_q.delete();
        done_id_q.delete();
        done_cyc_q.delete();
        mid_cyc = 0;
        mute = v.mute_v;

        req = v.first;
        @(posedge clk); #1;
        req = 4'd0;
        check($sformatf("%s_lat1_freq", tag), int'(freq_hz), 0);
        check($sformatf("%s_lat1_busy", tag), int'(busy), 0);
        @(posedge clk); #1;
        check($sformatf("%s_lat2_freq", tag), int'(freq_hz), 0);
        check($sformatf("%s_lat2_busy", tag), int'(busy), 1);
        @(posedge clk); #1;
        check($sformatf("%s_lat3_freq", tag), int'(freq_hz), rom_f[fid][0]);
        check($sformatf("%s_lat3_id", tag), int'(active_id), fid);

        if (v.mid != 4'd0) begin
            repeat (v.delay) @(posedge clk);
            #1;
            req = v.mid;
            mid_cyc = cyc;
            @(posedge clk); #1;
            req = 4'd0;
        end

        quiet = 0;
        guard = 0;
        while (quiet < 3 && guard < 22000) begin
            @(posedge clk); #1;
            guard++;
            if (!busy && freq_hz == 12'd0) quiet++;
            else quiet = 0;
        end
        check($sformatf("%s_idle_reached", tag), int'(quiet >= 3), 1);

        check($sformatf("%s_done_count", tag), done_id_q.size(), v.exp_n);
        check($sformatf("%s_done_model", tag), done_id_q.size(), exp_done.size());
        for (int i = 0; i < exp_done.size() && i < done_id_q.size(); i++)
            check($sformatf("%s_done%0d_id", tag, i), done_id_q[i], exp_done[i]);
        check($sformatf("%s_seg_count", tag), obs_q.size(), exp_q.size());
        if (obs_q.size() > 0)
            check($sformatf("%s_first_freq", tag), obs_q[0].freq, v.exp_first_freq);
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_seg%0d_freq", tag, i), obs_q[i].freq, exp_q[i].freq);
            if (!exp_q[i].skip)
                check_range($sformatf("%s_seg%0d_len", tag, i), obs_q[i].len,
                            exp_q[i].dur * CPT - 8, exp_q[i].dur * CPT + 1);
        end
        if (pre && done_cyc_q.size() > 0)
            check_range($sformatf("%s_preempt_lat", tag), done_cyc_q[0] - mid_cyc, 1, 2);
    endtask

    initial begin
        #(300_000 * 10);
        $display("FAIL watchdog: simulation exceeded 300000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t rv;
        int   n0;

        vecs[0] = '{first: 4'b0100, mid: 4'b0000, delay: 0,  mute_v: 1'b0, exp_n: 1, exp_first_freq: 196};
        vecs[1] = '{first: 4'b1100, mid: 4'b0000, delay: 0,  mute_v: 1'b0, exp_n: 2, exp_first_freq: 196};
        vecs[2] = '{first: 4'b0010, mid: 4'b0000, delay: 0,  mute_v: 1'b0, exp_n: 1, exp_first_freq: 523};
        vecs[3] = '{first: 4'b0001, mid: 4'b0000, delay: 0,  mute_v: 1'b1, exp_n: 1, exp_first_freq: 659};
        vecs[4] = '{first: 4'b1110, mid: 4'b0000, delay: 0,  mute_v: 1'b0, exp_n: 3, exp_first_freq: 523};
        vecs[5] = '{first: 4'b1000, mid: 4'b0001, delay: 20, mute_v: 1'b0, exp_n: 2, exp_first_freq: 880};

        reset_n = 1'b0;
        #12;
        check("rst_freq", int'(freq_hz), 0);
        check("rst_tone_en", int'(tone_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_active_id", int'(active_id), 0);
        check("rst_done", int'(done), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", int'(busy), 0);

        for (int k = 0; k < 6; k++) run_trial(vecs[k], $sformatf("vec%0d", k));

        for (int k = 0; k < 4; k++) begin
            rv.first          = 4'($urandom_range(1, 7)) << 1;
            rv.mid            = 4'($urandom_range(0, 7)) << 1;
            rv.delay          = int'($urandom_range(5, 150));
            rv.mute_v         = 1'($urandom_range(0, 1));
            rv.exp_first_freq = rom_f[lowest(rv.first)][0];
            rv.exp_n          = $countones((rv.first & ~(4'b0001 << lowest(rv.first))) | rv.mid)
                                + 1;
            run_trial(rv, $sformatf("rnd%0d", k));
        end

        // Asynchronous reset mid-note with another request pending.
        mute = 1'b0;
        req  = 4'b0010;
        @(posedge clk); #1;
        req  = 4'd0;
        repeat (60) @(posedge clk);
        #1;
        req  = 4'b1000;
        @(posedge clk); #1;
        req  = 4'd0;
        repeat (40) @(posedge clk);
        #3;
        check("mid_note_busy", int'(busy), 1);
        n0 = done_id_q.size();
        reset_n = 1'b0;
        #1;
        check("arst_freq", int'(freq_hz), 0);
        check("arst_tone_en", int'(tone_en), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_active_id", int'(active_id), 0);
        check("arst_done", int'(done), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst_pending_cleared", int'(busy), 0);
        check("arst_freq_after", int'(freq_hz), 0);
        check("arst_no_done", done_id_q.size(), n0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
